// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer handshake and status bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                     wr;
    logic [WIDTH-1:0]         din;
    logic                     rd;
    logic [WIDTH-1:0]         dout;
    logic                     dout_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;
    logic                     err_clr;

    modport master (
        output wr, din, rd, err_clr,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr, din, rd, err_clr,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, threshold and sticky error flags
// SYNC_FIFO_FWFT_EN selects first-word fall-through reads; default is registered 1-cycle read.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_param_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrptr;
    logic [AW-1:0]    rdptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;
    logic             wr_rej;
    logic             rd_rej;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    // A full FIFO can still take a write when the same cycle pops a word.
    assign rd_ok  = bus.rd && !empty;
    assign wr_ok  = bus.wr && (!full || rd_ok);
    assign wr_rej = bus.wr && !wr_ok;
    assign rd_rej = bus.rd && empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wrptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrptr   <= '0;
            rdptr   <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wrptr <= wrptr + 1'b1;
            end
            if (rd_ok) begin
                rdptr <= rdptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // A fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_rej) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (rd_rej) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.dout       = mem[rdptr];
    assign bus.dout_valid = !empty;
`else
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_ok;
            if (rd_ok) begin
                dout_q <= mem[rdptr];
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(DEPTH - AF_MARGIN));
    assign bus.almost_empty = (count_q <= CW'(AE_MARGIN));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(2), .AE_MARGIN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        bus.wr  = w;
        bus.din = d;
        bus.rd  = r;
        tick();
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
    endtask

    // Accepted transfer; when r is set, exp is the word expected at the head.
    task automatic xfer(input logic w, input logic [7:0] d, input logic r, input logic [7:0] exp);
        bus.wr  = w;
        bus.din = d;
        bus.rd  = r;
`ifdef SYNC_FIFO_FWFT_EN
        if (r) begin
            check("head_valid", bus.dout_valid, 1);
            check("head_data", bus.dout, exp);
        end
`endif
        tick();
`ifndef SYNC_FIFO_FWFT_EN
        check("dout_valid", bus.dout_valid, r);
        if (r) check("dout", bus.dout, exp);
`endif
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    initial begin
        bus.wr = 1'b0; bus.din = '0; bus.rd = 1'b0; bus.err_clr = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_udf", bus.underflow, 0);
        check("rst_ae", bus.almost_empty, 1);
        check("rst_af", bus.almost_full, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_dout", bus.dout, 0);
`endif
        rst = 1'b1;

        // basic write three, read three
        xfer(1, 8'h11, 0, 0);
        xfer(1, 8'h22, 0, 0);
        xfer(1, 8'h33, 0, 0);
        check("basic_count3", bus.count, 3);
        xfer(0, 0, 1, 8'h11);
        check("basic_count2", bus.count, 2);
        xfer(0, 0, 1, 8'h22);
        xfer(0, 0, 1, 8'h33);
        check("basic_count0", bus.count, 0);
        check("basic_empty", bus.empty, 1);
`ifndef SYNC_FIFO_FWFT_EN
        tick();
        check("idle_valid", bus.dout_valid, 0);
        check("idle_hold", bus.dout, 8'h33);
`endif

        // fill and overflow
        for (int i = 0; i < 16; i++) xfer(1, 8'(i), 0, 0);
        check("fill_full", bus.full, 1);
        check("fill_count", bus.count, 16);
        check("fill_ovf0", bus.overflow, 0);
        check("fill_af", bus.almost_full, 1);
        xfer(1, 8'h10, 0, 0);
        check("ovf_set", bus.overflow, 1);
        check("ovf_count", bus.count, 16);
        for (int i = 0; i < 16; i++) xfer(0, 0, 1, 8'(i));
        check("drain_empty", bus.empty, 1);
        check("ovf_sticky", bus.overflow, 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("ovf_clr", bus.overflow, 0);

        // simultaneous at count 5
        for (int i = 0; i < 5; i++) xfer(1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 10; i++) begin
            xfer(1, 8'(8'h45 + i), 1, 8'(8'h40 + i));
            check("sim_count5", bus.count, 5);
        end
        for (int i = 0; i < 5; i++) xfer(0, 0, 1, 8'(8'h4A + i));
        check("sim_empty", bus.empty, 1);

        // simultaneous at full
        for (int i = 0; i < 16; i++) xfer(1, 8'(8'h60 + i), 0, 0);
        xfer(1, 8'h70, 1, 8'h60);
        check("fullrw_full", bus.full, 1);
        check("fullrw_count", bus.count, 16);
        check("fullrw_ovf", bus.overflow, 0);
        for (int i = 0; i < 15; i++) xfer(0, 0, 1, 8'(8'h61 + i));
        xfer(0, 0, 1, 8'h70);
        check("fullrw_empty", bus.empty, 1);

        // empty with write and read together
        cyc(1, 8'hA5, 1);
        check("erw_count", bus.count, 1);
        check("erw_udf", bus.underflow, 1);
`ifdef SYNC_FIFO_FWFT_EN
        check("erw_valid", bus.dout_valid, 1);
        check("erw_head", bus.dout, 8'hA5);
`else
        check("erw_valid", bus.dout_valid, 0);
`endif
        xfer(0, 0, 1, 8'hA5);
        check("erw_count0", bus.count, 0);
        bus.err_clr = 1'b1;
        cyc(0, 0, 1);
        check("udf_err_wins", bus.underflow, 1);
        tick();
        bus.err_clr = 1'b0;
        check("udf_clr", bus.underflow, 0);

        // thresholds and wrap: 40 words total
        for (int i = 0; i < 14; i++) begin
            xfer(1, 8'(8'h80 + i), 0, 0);
            check("af_up", bus.almost_full, (i + 1) >= 14);
            check("ae_up", bus.almost_empty, (i + 1) <= 2);
        end
        for (int i = 0; i < 26; i++) begin
            xfer(1, 8'(8'h8E + i), 1, 8'(8'h80 + i));
            check("wrap_count", bus.count, 14);
        end
        for (int i = 0; i < 14; i++) begin
            xfer(0, 0, 1, 8'(8'h9A + i));
            check("af_dn", bus.almost_full, (13 - i) >= 14);
            check("ae_dn", bus.almost_empty, (13 - i) <= 2);
        end

        // reset mid-operation
        cyc(0, 0, 1);
        check("pre_rst_udf", bus.underflow, 1);
        for (int i = 0; i < 7; i++) xfer(1, 8'(8'h30 + i), 0, 0);
        check("pre_rst_count", bus.count, 7);
        rst = 1'b0;
        cyc(1, 8'h99, 1);
        rst = 1'b1;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_empty", bus.empty, 1);
        check("mid_rst_udf", bus.underflow, 0);
        check("mid_rst_ovf", bus.overflow, 0);
        check("mid_rst_valid", bus.dout_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("mid_rst_dout", bus.dout, 0);
`endif
        xfer(1, 8'h5A, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_valid", bus.dout_valid, 1);
        check("fwft_data", bus.dout, 8'h5A);
`endif
        xfer(0, 0, 1, 8'h5A);
        check("post_rst_empty", bus.empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the next generation of the team's 8x16 buffer. Generalises data width and depth, and accepts a read and a write in the same cycle. Adds a live occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Sits between producer/consumer datapaths in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_MARGIN, 2, almost_full asserts when free slots <= AF_MARGIN (0..DEPTH-1)
AE_MARGIN, 2, almost_empty asserts when occupancy <= AE_MARGIN (0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
wr  input  1  write request
din  input  WIDTH  write data
rd  input  1  read request
dout  output  WIDTH  read data
dout_valid  output  1  dout holds valid popped data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= DEPTH-AF_MARGIN
almost_empty  output  1  count <= AE_MARGIN
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
err_clr  input  1  clears overflow/underflow

Behaviour:
- Reset: rst==0 sampled at a rising edge forces wrptr=0, rdptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory contents are not reset. Reset overrides all other inputs in that cycle, including mid-burst.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- wr_ok = wr && (!full || rd_ok). rd_ok = rd && !empty.
- Full with wr&&rd: both accepted, count unchanged, pointers both advance.
- Empty with wr&&rd: write accepted, read rejected (underflow set), count -> 1.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Rejected write (wr && full && !rd_ok): memory and wrptr unchanged; overflow<=1.
- Rejected read (rd && empty): rdptr unchanged, dout holds; underflow<=1.
- Sticky flags hold until err_clr==1, which clears them at the next edge. If a new error occurs in the same cycle as err_clr, the error wins (flag stays 1).
- full, empty, almost_full and almost_empty are combinational decodes of the count register, so they reflect state after each edge.
- Standard mode: on rd_ok at edge N, dout<=mem[rdptr] and dout_valid<=1 at edge N (1-cycle read latency). dout_valid<=0 in any cycle without rd_ok; dout holds its last value.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN. Defined: first-word fall-through mode.
- dout = mem[rdptr] combinationally; dout_valid = !empty.
- rd acts as an acknowledge that pops the head.
- Data written at edge N appears on dout after edge N when the FIFO was empty.
- The reset value of dout is don't-care while dout_valid==0.
Undefined: standard registered-read behaviour as above.

Test Plan:
- Reset/basic: rst=0 for 2 cycles, then write 0x11,0x22,0x33 and read 3 -> dout 0x11,0x22,0x33 each one cycle after rd with dout_valid=1; count 3->0; empty=1.
- Fill/overflow (DEPTH=16): 17 writes of 0x00..0x10 -> full=1 after the 16th, count=16, overflow=1 after the 17th; 16 reads return 0x00..0x0F (0x10 dropped).
- Simultaneous: at count=5 assert wr&&rd for 10 cycles -> count stays 5, FIFO order preserved. At full, wr&&rd -> both accepted, full stays 1, overflow stays 0.
- Empty edge: empty, wr=1 rd=1 with din=0xA5 -> count=1, underflow=1, dout_valid=0. Next cycle rd -> dout=0xA5. err_clr pulse -> underflow=0.
- Thresholds/wrap: AF_MARGIN=2, AE_MARGIN=2. Stream 40 words with interleaved reads -> almost_full=1 exactly at count>=14, almost_empty=1 at count<=2, data intact across pointer wrap.
- Reset mid-operation and FWFT: rst=0 at count=7 -> count=0, empty=1, flags 0 next cycle. With SYNC_FIFO_FWFT_EN, write 0x5A to empty -> dout=0x5A and dout_valid=1 right after the write edge, without rd.
